// File: rtl/audio_pkg.sv
// Shared constants and types for the codec serdes slice (sample width,
// channel codes, default clock-divider and slot-length settings).
package audio_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int BCLK_DIV_DEF = 4;
    localparam int CH_BITS_DEF  = 32;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock / LR-clock generator: slot counters, BCLK, LRCK and per-cycle strobes.
// AUDIO_I2S_FORMAT_EN selects the I2S LRCK polarity (0 = left) instead of left-justified.
module audio_bclk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEF,
    parameter int CH_BITS  = CH_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [$clog2(CH_BITS)-1:0] bit_cnt,
    output logic                       slot_start,
    output logic                       rise,
    output logic                       fall,
    output logic                       pre_slot_end,
    output logic                       channel_sel,
    output logic                       bclk,
    output logic                       lrck
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(CH_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CH_BITS - 1);

`ifdef AUDIO_I2S_FORMAT_EN
    localparam logic LRCK_RST = 1'b0;
`else
    localparam logic LRCK_RST = 1'b1;
`endif

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             div_wrap;
    logic             bit_wrap;

    assign div_wrap     = (div_cnt == DIV_LAST);
    assign bit_wrap     = (bit_cnt == BIT_LAST);
    assign div_nxt      = div_wrap ? '0 : div_cnt + 1'b1;
    assign rise         = (div_cnt == DIV_HALF - 1'b1);
    assign fall         = div_wrap;
    assign slot_start   = (bit_cnt == '0) && (div_cnt == '0);
    // One cycle early so the registered sample_req lands on the last slot cycle.
    assign pre_slot_end = bit_wrap && (div_cnt == DIV_LAST - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            channel_sel <= CH_LEFT;
            bclk        <= 1'b0;
            lrck        <= LRCK_RST;
        end else begin
            div_cnt <= div_nxt;
            bclk    <= (div_nxt >= DIV_HALF);
            if (div_wrap) begin
                bit_cnt <= bit_wrap ? '0 : bit_cnt + 1'b1;
                if (bit_wrap) begin
                    channel_sel <= (channel_sel == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                    lrck        <= ~lrck;
                end
            end
        end
    end

endmodule

// File: rtl/audio_codec_serdes.sv
// Codec-side serdes: drives BCLK/LRCK as master, shifts DAC samples out and ADC samples in.
// AUDIO_I2S_FORMAT_EN selects Philips I2S (MSB one BCLK late); default is left-justified.
module audio_codec_serdes #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int BCLK_DIV = audio_pkg::BCLK_DIV_DEF,
    parameter int CH_BITS  = audio_pkg::CH_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       sample_req,
    output logic                       sample_end,
    output logic                       channel_sel,
    input  logic signed [SAMPLE_W-1:0] audio_output,
    output logic signed [SAMPLE_W-1:0] audio_input,
    output logic                       AUD_BCLK,
    output logic                       AUD_DACLRCK,
    output logic                       AUD_ADCLRCK,
    output logic                       AUD_DACDAT,
    input  logic                       AUD_ADCDAT
);
    import audio_pkg::*;

`ifdef AUDIO_I2S_FORMAT_EN
    localparam int TX_W     = SAMPLE_W + 1;
    localparam int RX_FIRST = 1;
`else
    localparam int TX_W     = SAMPLE_W;
    localparam int RX_FIRST = 0;
`endif

    localparam int               BIT_W    = $clog2(CH_BITS);
    localparam logic [BIT_W-1:0] RX_LO    = BIT_W'(RX_FIRST);
    localparam logic [BIT_W-1:0] RX_BITS  = BIT_W'(SAMPLE_W);
    localparam logic [BIT_W-1:0] RX_LASTI = BIT_W'(SAMPLE_W - 1);

    logic [BIT_W-1:0]    bit_cnt;
    logic                slot_start;
    logic                rise;
    logic                fall;
    logic                pre_slot_end;
    logic                lrck;
    logic                primed;
    logic [TX_W-1:0]     tx_sh;
    logic [TX_W-1:0]     tx_nxt;
    logic [SAMPLE_W-2:0] rx_sh;
    logic [SAMPLE_W-1:0] rx_word;
    logic [BIT_W-1:0]    rx_idx;
    logic                rx_bit;
    logic                rx_last;

    audio_bclk_gen #(
        .BCLK_DIV (BCLK_DIV),
        .CH_BITS  (CH_BITS)
    ) u_bclk (
        .clk          (clk),
        .reset        (reset),
        .bit_cnt      (bit_cnt),
        .slot_start   (slot_start),
        .rise         (rise),
        .fall         (fall),
        .pre_slot_end (pre_slot_end),
        .channel_sel  (channel_sel),
        .bclk         (AUD_BCLK),
        .lrck         (lrck)
    );

    assign AUD_DACLRCK = lrck;
    assign AUD_ADCLRCK = lrck;

    // Bit positions before the receive window wrap to large values and fall outside it.
    assign rx_idx  = bit_cnt - RX_LO;
    assign rx_bit  = rise && (rx_idx < RX_BITS);
    assign rx_last = (rx_idx == RX_LASTI);
    assign rx_word = {rx_sh, AUD_ADCDAT};

    // DACDAT follows the next shift MSB so the loaded MSB is valid before the first BCLK rise.
    always_comb begin
        tx_nxt = tx_sh;
        if (slot_start) begin
            tx_nxt = primed ? TX_W'($unsigned(audio_output)) : '0;
        end else if (fall) begin
            tx_nxt = {tx_sh[TX_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed      <= 1'b0;
            sample_req  <= 1'b0;
            sample_end  <= 1'b0;
            tx_sh       <= '0;
            AUD_DACDAT  <= 1'b0;
            rx_sh       <= '0;
            audio_input <= '0;
        end else begin
            sample_req <= pre_slot_end;
            if (sample_req) begin
                primed <= 1'b1;
            end
            tx_sh      <= tx_nxt;
            AUD_DACDAT <= tx_nxt[TX_W-1];
            sample_end <= rx_bit && rx_last;
            if (rx_bit) begin
                rx_sh <= rx_word[SAMPLE_W-2:0];
                if (rx_last) begin
                    audio_input <= $signed(rx_word);
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_codec_serdes.sv
// Directed bench for audio_codec_serdes: per-slot vector table plus reset sequences.
module tb_audio_codec_serdes;

`ifdef AUDIO_I2S_FORMAT_EN
    localparam int   SE_CYC    = 66;
    localparam int   RX_OFF    = 1;
    localparam logic LRCK_LEFT = 1'b0;
`else
    localparam int   SE_CYC    = 62;
    localparam int   RX_OFF    = 0;
    localparam logic LRCK_LEFT = 1'b1;
`endif
    localparam int NV = 14;

    typedef struct {
        logic        loop;
        logic [15:0] dac;
        logic [15:0] adc;
        logic [15:0] exp_dac;
        logic [15:0] exp_in;
    } vec_t;

    vec_t vec [NV];

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_req, sample_end, channel_sel;
    logic [15:0] audio_output;
    logic [15:0] audio_input;
    logic        AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT, AUD_ADCDAT;
    logic        adc_drv = 1'b0;
    logic        loop_en;
    logic [31:0] dac_cap = '0;
    logic        run;
    int          slot_base;
    int          cyc;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign AUD_ADCDAT = loop_en ? AUD_DACDAT : adc_drv;

    audio_codec_serdes dut (
        .clk          (clk),
        .reset        (reset),
        .sample_req   (sample_req),
        .sample_end   (sample_end),
        .channel_sel  (channel_sel),
        .audio_output (audio_output),
        .audio_input  (audio_input),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .AUD_ADCDAT   (AUD_ADCDAT)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [31:0] exp_frame(input logic [15:0] w);
`ifdef AUDIO_I2S_FORMAT_EN
        return {1'b0, w, 15'h0};
`else
        return {w, 16'h0};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".sample_req"},  sample_req,  1'b0);
        check({tag, ".sample_end"},  sample_end,  1'b0);
        check({tag, ".channel_sel"}, channel_sel, 1'b0);
        check({tag, ".audio_input"}, audio_input, 16'h0000);
        check({tag, ".bclk"},        AUD_BCLK,    1'b0);
        check({tag, ".dacdat"},      AUD_DACDAT,  1'b0);
        check({tag, ".daclrck"},     AUD_DACLRCK, LRCK_LEFT);
        check({tag, ".adclrck"},     AUD_ADCLRCK, LRCK_LEFT);
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 5000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wait_cyc: cycle %0d not reached (at %0d)", n, cyc);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        end
    endtask

    // Present each slot's DAC word in its load cycle, then scramble it.
    task automatic run_slots(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            wait_cyc((k - first) * 128);
            audio_output = vec[k].dac;
            loop_en      = vec[k].loop;
            wait_cyc((k - first) * 128 + 1);
            audio_output = ~vec[k].dac;
        end
        wait_cyc((last - first + 1) * 128);
    endtask

    // Cycle-accurate monitor plus codec model (DAC capture at BCLK rise, ADC drive).
    always @(negedge clk) begin
        if (run) begin
            int   s, rel, k, b;
            logic ch;
            s   = cyc % 128;
            rel = cyc / 128;
            k   = slot_base + rel;
            b   = s / 4;
            ch  = rel[0];
            check("sample_req",  sample_req,  s == 127);
            check("sample_end",  sample_end,  s == SE_CYC);
            check("bclk",        AUD_BCLK,    (s % 4) >= 2);
            check("channel_sel", channel_sel, ch);
            check("daclrck",     AUD_DACLRCK, LRCK_LEFT ^ ch);
            check("adclrck",     AUD_ADCLRCK, LRCK_LEFT ^ ch);
            if ((s % 4) == 1) dac_cap = {dac_cap[30:0], AUD_DACDAT};
            if (k < NV) begin
                if (s == 127)    check("dac_slot", dac_cap, exp_frame(vec[k].exp_dac));
                if (s == SE_CYC) check("audio_input", audio_input, vec[k].exp_in);
                adc_drv = (b >= RX_OFF && b < RX_OFF + 16) ? vec[k].adc[15 - (b - RX_OFF)] : 1'b0;
            end
        end
    end

    initial begin
        //             loop  dac       adc       exp_dac   exp_in
        vec[0]  = '{1'b0, 16'h1111, 16'h1234, 16'h0000, 16'h1234};
        vec[1]  = '{1'b0, 16'hA5C3, 16'hFEDC, 16'hA5C3, 16'hFEDC};
        vec[2]  = '{1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001};
        vec[3]  = '{1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vec[4]  = '{1'b0, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h7FFF};
        vec[5]  = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        vec[6]  = '{1'b1, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
        vec[7]  = '{1'b1, 16'h8000, 16'h0000, 16'h8000, 16'h8000};
        vec[8]  = '{1'b1, 16'h8000, 16'h0000, 16'h8000, 16'h8000};
        vec[9]  = '{1'b1, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
        vec[10] = '{1'b0, 16'hFFFF, 16'hAAAA, 16'hFFFF, 16'hAAAA};
        vec[11] = '{1'b0, 16'hFFFF, 16'h5555, 16'hFFFF, 16'h5555};
        vec[12] = '{1'b0, 16'hFFFF, 16'h1357, 16'h0000, 16'h1357};
        vec[13] = '{1'b0, 16'h2468, 16'h9BDF, 16'h2468, 16'h9BDF};

        run          = 1'b0;
        slot_base    = 0;
        loop_en      = 1'b0;
        audio_output = 16'h0000;
        reset        = 1'b1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_checks("in_reset");
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        run   = 1'b1;

        run_slots(0, 10);

        // Right slot, bit 10, BCLK high: abort the frame asynchronously.
        audio_output = vec[11].dac;
        loop_en      = vec[11].loop;
        wait_cyc(11 * 128 + 42);
        run   = 1'b0;
        reset = 1'b1;
        #1;
        reset_checks("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        slot_base = 12;
        run       = 1'b1;

        run_slots(12, 13);
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
